// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream, stages up to 16 program entries and commits them to
// the 4-bit computer's programming port. Define LOADER_CSUM_EN to require a trailing checksum byte.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic       prog_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [3:0] prog_add,
  output logic [7:0] prog_in,
  output logic [3:0] data_nib,
  output logic       prog_we,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned AW    = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned NW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [AW-1:0] HOLD_INIT = AW'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_INS, S_DATA, S_CSUM, S_COMMIT, S_HOLD, S_ERR
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] nm1_q;
  logic [AW-1:0] hold_q;
`ifdef LOADER_CSUM_EN
  logic [BW-1:0] csum_q;
`endif
  logic          rx_ready_q;
  logic          prog_we_q;
  logic [AW-1:0] prog_add_q;
  logic [BW-1:0] prog_in_q;
  logic [NW-1:0] data_nib_q;
  logic          cpu_reset_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [BW-1:0] stage_ins_q [DEPTH];
  logic [NW-1:0] stage_dat_q [DEPTH];

  logic          acc;
  logic          data_ok;
  logic [AW-1:0] idx_inc;

  assign acc     = rx_valid & rx_ready_q;
  assign data_ok = (rx_data[7:4] == 4'd0);
  assign idx_inc = idx_q + AW'(1);

  // Staging buffer: written during receive, deliberately left untouched by reset.
  always_ff @(posedge prog_clk) begin
    if (!reset && acc && state_q == S_INS) begin
      stage_ins_q[idx_q] <= rx_data;
    end
    if (!reset && acc && state_q == S_DATA && data_ok) begin
      stage_dat_q[idx_q] <= rx_data[NW-1:0];
    end
  end

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      nm1_q       <= '0;
      hold_q      <= '0;
`ifdef LOADER_CSUM_EN
      csum_q      <= '0;
`endif
      rx_ready_q  <= 1'b1;
      prog_we_q   <= 1'b0;
      prog_add_q  <= '0;
      prog_in_q   <= '0;
      data_nib_q  <= '0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ERR: begin
          if (acc && rx_data == SYNC_BYTE) begin
            state_q <= S_COUNT;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        S_COUNT: begin
          if (acc) begin
            if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              nm1_q   <= AW'(rx_data - 8'd1);
              idx_q   <= '0;
              state_q <= S_INS;
`ifdef LOADER_CSUM_EN
              csum_q  <= csum_q + rx_data;
`endif
            end
          end
        end
        S_INS: begin
          if (acc) begin
            state_q <= S_DATA;
`ifdef LOADER_CSUM_EN
            csum_q  <= csum_q + rx_data;
`endif
          end
        end
        S_DATA: begin
          if (acc) begin
            if (!data_ok) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (idx_q != nm1_q) begin
              idx_q   <= idx_inc;
              state_q <= S_INS;
`ifdef LOADER_CSUM_EN
              csum_q  <= csum_q + rx_data;
            end else begin
              csum_q  <= csum_q + rx_data;
              state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (acc) begin
            if (rx_data != csum_q) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q     <= S_COMMIT;
              idx_q       <= '0;
              rx_ready_q  <= 1'b0;
              prog_we_q   <= 1'b1;
              cpu_reset_q <= 1'b1;
              prog_add_q  <= '0;
              prog_in_q   <= stage_ins_q[0];
              data_nib_q  <= stage_dat_q[0];
            end
          end
        end
`else
            end else begin
              // Single-entry frames present the nibble being accepted on this same edge.
              state_q     <= S_COMMIT;
              idx_q       <= '0;
              rx_ready_q  <= 1'b0;
              prog_we_q   <= 1'b1;
              cpu_reset_q <= 1'b1;
              prog_add_q  <= '0;
              prog_in_q   <= stage_ins_q[0];
              data_nib_q  <= (nm1_q == '0) ? rx_data[NW-1:0] : stage_dat_q[0];
            end
          end
        end
`endif
        S_COMMIT: begin
          if (idx_q == nm1_q) begin
            prog_we_q <= 1'b0;
            hold_q    <= HOLD_INIT;
            state_q   <= S_HOLD;
          end else begin
            idx_q      <= idx_inc;
            prog_add_q <= idx_inc;
            prog_in_q  <= stage_ins_q[idx_inc];
            data_nib_q <= stage_dat_q[idx_inc];
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            rx_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            hold_q <= hold_q - AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign prog_we   = prog_we_q;
  assign prog_add  = prog_add_q;
  assign prog_in   = prog_in_q;
  assign data_nib  = data_nib_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame-level reference model, per-cycle output compare, directed and random frames.
module tb_prog_loader;

  localparam int HOLD = 4;

  logic       prog_clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] prog_add;
  logic [7:0] prog_in;
  logic [3:0] data_nib;
  logic       prog_we;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;

  prog_loader dut (
    .prog_clk (prog_clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .prog_add (prog_add),
    .prog_in  (prog_in),
    .data_nib (data_nib),
    .prog_we  (prog_we),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Reference model state: bytes of the current frame, and a commit timeline counter.
  bit         m_on;
  bit         infrm;
  bit         active;
  int         j;
  int         n;
  logic [7:0] fb[$];
  logic [7:0] ins_e[16];
  logic [3:0] dat_e[16];
  logic       e_ready, e_we, e_cpu, e_busy, e_done, e_err;
  logic [3:0] e_add, e_nib;
  logic [7:0] e_in;

  int         n_checks;
  int         n_errors;
  int         tot_we, tot_cpu, tot_done;
  logic [3:0] wr_add[$];
  logic [7:0] wr_in[$];
  logic [3:0] wr_nib[$];
  logic [7:0] tx[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] b;
    logic [7:0] s;
    int L;
    int nn;
    bit bad;
    bit good;
    if (reset) begin
      m_on = 1; infrm = 0; active = 0; fb.delete();
      e_ready = 1; e_we = 0; e_add = 0; e_in = 0; e_nib = 0;
      e_cpu = 0; e_busy = 0; e_done = 0; e_err = 0;
      return;
    end
    if (!m_on) return;
    e_done = 0;
    if (active) begin
      j++;
      e_we = (j <= n);
      if (j <= n) begin
        e_add = 4'(j - 1); e_in = ins_e[j-1]; e_nib = dat_e[j-1];
      end
      e_cpu = (j <= n + HOLD);
      if (j == n + HOLD + 1) begin
        e_done = 1; e_busy = 0; e_ready = 1; active = 0;
      end
    end else if (rx_valid && e_ready) begin
      b = rx_data;
      if (!infrm) begin
        if (b == 8'hA5) begin
          infrm = 1; fb.delete(); e_busy = 1; e_err = 0;
        end
      end else begin
        fb.push_back(b);
        L = fb.size();
        nn = int'(fb[0]);
        bad = 0; good = 0;
        if (L == 1) begin
          bad = (nn == 0 || nn > 16);
        end else if (L <= 1 + 2 * nn) begin
          if ((L % 2) == 1 && b[7:4] != 4'd0) bad = 1;
`ifndef LOADER_CSUM_EN
          if (!bad && L == 1 + 2 * nn) good = 1;
`endif
        end else begin
          s = 8'h00;
          for (int k = 0; k < L - 1; k++) s = s + fb[k];
          if (s == b) good = 1; else bad = 1;
        end
        if (bad) begin
          infrm = 0; e_err = 1; e_busy = 0;
        end else if (good) begin
          infrm = 0; n = nn;
          for (int k = 0; k < nn; k++) begin
            ins_e[k] = fb[1 + 2 * k];
            dat_e[k] = fb[2 + 2 * k][3:0];
          end
          active = 1; j = 1;
          e_we = 1; e_add = 0; e_in = ins_e[0]; e_nib = dat_e[0];
          e_cpu = 1; e_ready = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [21:0] a;
    logic [21:0] e;
    a = {rx_ready, prog_we, prog_add, prog_in, data_nib, cpu_reset, busy, done, err};
    e = {e_ready, e_we, e_add, e_in, e_nib, e_cpu, e_busy, e_done, e_err};
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL outputs t=%0t got %h expected %h (ready,we,add,in,nib,cpu,busy,done,err)",
               $time, a, e);
    end
    if (prog_we === 1'b1) begin
      tot_we++;
      wr_add.push_back(prog_add); wr_in.push_back(prog_in); wr_nib.push_back(data_nib);
    end
    if (cpu_reset === 1'b1) tot_cpu++;
    if (done === 1'b1) tot_done++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int  g;
    bit  r;
    bit  ok;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (g) begin
      rx_valid = 1'b0; rx_data = 8'($urandom);
      @(posedge prog_clk); #1;
    end
    rx_data = b; rx_valid = 1'b1; ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge prog_clk); r = rx_ready;
      @(posedge prog_clk); #1;
      if (r) begin ok = 1; break; end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_tx(input int gapmax);
    for (int k = 0; k < tx.size(); k++) send_byte(tx[k], gapmax);
  endtask

  task automatic add_csum();
`ifdef LOADER_CSUM_EN
    logic [7:0] s;
    int from;
    from = -1;
    for (int k = 0; k < tx.size(); k++)
      if (from < 0 && tx[k] == 8'hA5) from = k + 1;
    s = 8'h00;
    for (int k = from; k < tx.size(); k++) s = s + tx[k];
    tx.push_back(s);
`endif
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (!active) begin ok = 1; break; end
      @(posedge prog_clk); #1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  task automatic stimulus();
    int s_we, s_cpu, s_done, wq, nn;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge prog_clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", int'(rx_ready), 1);
    chk("rst_we", int'(prog_we), 0);
    chk("rst_cpu", int'(cpu_reset), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_add", int'(prog_add), 0);

    // Single-entry frame
    s_we = tot_we; s_cpu = tot_cpu; s_done = tot_done; wq = wr_add.size();
    tx = '{8'hA5, 8'h01, 8'hF0, 8'h00}; add_csum();
    send_tx(0); wait_idle();
    chk("single_writes", tot_we - s_we, 1);
    chk("single_add", int'(wr_add[wq]), 0);
    chk("single_ins", int'(wr_in[wq]), 8'hF0);
    chk("single_nib", int'(wr_nib[wq]), 0);
    chk("single_cpu_cycles", tot_cpu - s_cpu, 1 + HOLD);
    chk("single_done", tot_done - s_done, 1);
    chk("single_err", int'(err), 0);

    // Full 16-entry frame with gaps
    s_we = tot_we; s_cpu = tot_cpu; wq = wr_add.size();
    tx.delete(); tx.push_back(8'hA5); tx.push_back(8'h10);
    for (int i = 0; i < 16; i++) begin tx.push_back(8'(i)); tx.push_back(8'(i)); end
    add_csum();
    send_tx(3); wait_idle();
    chk("full_writes", tot_we - s_we, 16);
    chk("full_last_add", int'(wr_add[wq + 15]), 15);
    chk("full_last_ins", int'(wr_in[wq + 15]), 8'h0F);
    chk("full_cpu_cycles", tot_cpu - s_cpu, 16 + HOLD);

    // Bad frame, then a good one clears err
    s_we = tot_we; s_cpu = tot_cpu;
`ifdef LOADER_CSUM_EN
    tx = '{8'hA5, 8'h01, 8'h70, 8'h03, 8'h00};
`else
    tx = '{8'hA5, 8'h01, 8'h70, 8'h33};
`endif
    send_tx(1);
    chk("bad_err", int'(err), 1);
    repeat (8) @(posedge prog_clk);
    #1;
    chk("bad_writes", tot_we - s_we, 0);
    chk("bad_cpu", tot_cpu - s_cpu, 0);
    s_we = tot_we;
    tx = '{8'hA5, 8'h02, 8'h11, 8'h01, 8'h22, 8'h02}; add_csum();
    send_tx(1);
    chk("recover_err", int'(err), 0);
    wait_idle();
    chk("recover_writes", tot_we - s_we, 2);

    // Illegal fields
    s_we = tot_we;
    tx = '{8'hA5, 8'h00}; send_tx(0);
    chk("n0_err", int'(err), 1);
    tx = '{8'hA5, 8'h11}; send_tx(0);
    chk("n17_err", int'(err), 1);
    tx = '{8'hA5, 8'h02, 8'h55, 8'h13}; send_tx(0);
    chk("datahi_err", int'(err), 1);
    repeat (4) @(posedge prog_clk);
    #1;
    chk("illegal_writes", tot_we - s_we, 0);

    // Reset on the 3rd write of an 8-entry commit
    s_we = tot_we;
    tx.delete(); tx.push_back(8'hA5); tx.push_back(8'h08);
    for (int i = 0; i < 8; i++) begin tx.push_back(8'($urandom)); tx.push_back(8'($urandom_range(0, 15))); end
    add_csum();
    send_tx(0);
    repeat (2) @(posedge prog_clk);
    #1;
    chk("mid_we", int'(prog_we), 1);
    chk("mid_add", int'(prog_add), 2);
    reset = 1'b1;
    @(posedge prog_clk); #1;
    reset = 1'b0;
    chk("after_rst_we", int'(prog_we), 0);
    chk("after_rst_add", int'(prog_add), 0);
    chk("after_rst_cpu", int'(cpu_reset), 0);
    chk("after_rst_ready", int'(rx_ready), 1);
    repeat (5) @(posedge prog_clk);
    #1;
    chk("mid_writes", tot_we - s_we, 3);

    // Leading noise
    s_we = tot_we; s_done = tot_done; wq = wr_add.size();
    tx = '{8'h00, 8'h37, 8'hA5, 8'h02, 8'h71, 8'h00, 8'h40, 8'h00}; add_csum();
    send_tx(2); wait_idle();
    chk("noise_writes", tot_we - s_we, 2);
    chk("noise_ins0", int'(wr_in[wq]), 8'h71);
    chk("noise_ins1", int'(wr_in[wq + 1]), 8'h40);
    chk("noise_add1", int'(wr_add[wq + 1]), 1);
    chk("noise_done", tot_done - s_done, 1);

    // Random frames with occasional corruption
    for (int f = 0; f < 25; f++) begin
      tx.delete();
      if ($urandom_range(0, 3) == 0) tx.push_back(8'($urandom_range(0, 8'hA4)));
      tx.push_back(8'hA5);
      nn = int'($urandom_range(1, 16));
      tx.push_back(8'(nn));
      for (int i = 0; i < nn; i++) begin
        tx.push_back(8'($urandom)); tx.push_back(8'($urandom_range(0, 15)));
      end
      add_csum();
      if ($urandom_range(0, 3) == 0) tx[$urandom_range(0, tx.size() - 1)] = 8'($urandom);
      send_tx(2);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    tot_we = 0; tot_cpu = 0; tot_done = 0;
    m_on = 0; infrm = 0; active = 0; j = 0; n = 0;
    fork
      forever begin
        @(posedge prog_clk);
        model_step();
      end
      forever begin
        @(negedge prog_clk);
        if (m_on) compare();
      end
      stimulus();
    join_any
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the 4-bit computer's programming port.
- Accepts a framed byte stream from a host byte source (for example, a UART receiver) over a valid/ready handshake, and stages up to 16 instruction/data entries.
- Validates the frame, then commits the entries, one per cycle, onto prog_add / prog_in / the data nibble.
- Holds the CPU in reset while it loads, and for a short period after.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- RST_HOLD, 4, number of prog_clk cycles cpu_reset stays high after the last commit write (legal range 1-15).

Ports:
- prog_clk  input  1  loader clock; also the computer's programming clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid and rx_ready are both high on a prog_clk rising edge.
- prog_add  output  4  programming address.
- prog_in  output  8  instruction byte: opcode in [7:4], operand in [3:0].
- data_nib  output  4  data-memory nibble for the same address.
- prog_we  output  1  commit write strobe; the address/data outputs are valid while it is high.
- cpu_reset  output  1  drives the computer's reset.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky frame error.

Behaviour:
- Reset: reset is synchronous, active-high; clock is prog_clk. On reset:
  - state goes to IDLE.
  - rx_ready=1; prog_we=0; prog_add=0; prog_in=0; data_nib=0; cpu_reset=0; busy=0; done=0; err=0.
  - count, index, checksum and hold counter are cleared.
  - The staging buffer is not cleared.
- Reset mid-frame or mid-commit: the frame is abandoned immediately and there are no further prog_we pulses. Entries already written to the computer stay written.
- Frame format: SYNC_BYTE, N, then N pairs of (INS byte, DATA byte), then CSUM.
  - N must be 1..16.
  - DATA[7:4] must be 0.
  - CSUM = 8-bit wrap-around sum of N and all 2N payload bytes.
- States and transitions:
  - IDLE: rx_ready=1. A SYNC_BYTE byte moves to COUNT, sets busy=1, clears the checksum. Any other byte is discarded.
  - COUNT: N=0 or N>16 moves to ERR. Otherwise store N, add N to the checksum, set index=0, move to INS.
  - INS: write the byte to stage[index].ins, add it to the checksum, move to DATA.
  - DATA: a nonzero upper nibble moves to ERR. Otherwise write stage[index].dat and add to the checksum. If index==N-1, move to CSUM; else index+1 and move to INS.
  - CSUM: on a mismatch, move to ERR. On a match, move to COMMIT with index=0, and cpu_reset=1 starting the next cycle.
  - COMMIT: rx_ready=0; prog_we=1; prog_add=index; prog_in=stage[index].ins; data_nib=stage[index].dat.
    - Exactly N consecutive prog_we cycles, for addresses 0..N-1.
    - Then prog_we=0 and move to HOLD.
    - Addresses N..15 are not written.
  - HOLD: rx_ready=0; cpu_reset=1 for RST_HOLD cycles. Then cpu_reset=0, done=1 for one cycle, busy=0, move to IDLE.
  - ERR: err=1, busy=0, cpu_reset=0, rx_ready=1, and no writes are made.
    - A SYNC_BYTE byte clears err and moves to COUNT; other bytes are discarded.
    - err is set on the cycle after the offending byte.
- A SYNC_BYTE value inside COUNT/INS/DATA/CSUM is treated as ordinary data; there is no resync mid-frame.
- Gaps in rx_valid are allowed in any receive state; the state is held.
- Latency from the CSUM acceptance edge:
  - first prog_we at +1 cycle;
  - last prog_we at +N;
  - done pulse at +N+RST_HOLD+1.
- Outputs are registered. prog_add, prog_in and data_nib hold their last values when prog_we=0.

Optional Feature:
- Macro LOADER_CSUM_EN.
- Defined: the CSUM byte is required and checked, as described above.
- Undefined: there is no CSUM byte, and no checksum logic is synthesized. DATA of the last entry moves directly to COMMIT, so first prog_we comes one cycle after the final DATA byte is accepted.

Test Plan:
- Single-entry frame. Send A5,01,F0,00,F1 with LOADER_CSUM_EN defined -> one prog_we cycle with prog_add=0, prog_in=F0, data_nib=0. cpu_reset is high for 1+4 cycles, then done pulses once; err=0.
- Full 16-entry frame. Send 16 pairs with INS=i, DATA=i and a correct CSUM; insert random rx_valid gaps -> 16 consecutive prog_we cycles at addresses 0..15 with matching values, and rx_ready=0 throughout COMMIT/HOLD.
- Bad checksum. Send A5,01,70,03 followed by a wrong CSUM of 00 (correct is 74) -> no prog_we, err=1, cpu_reset stays 0. A subsequent valid frame clears err and loads.
- Illegal fields. N=00, then a separate frame with N=11, then a DATA byte of 0x13 -> ERR on the offending byte each time, with zero writes.
- Reset mid-commit. Assert reset on the 3rd prog_we cycle of an N=8 frame -> prog_we low on the next edge, all outputs return to their reset values, and state is IDLE.
- Leading noise plus LOADER_CSUM_EN undefined. Send 00,37,A5,02,71,00,40,00 -> leading bytes ignored; writes at address 0 with prog_in 71 and address 1 with prog_in 40; done pulses.
